// File: rtl/vin_wr_agen_pkg.sv
// vin_pkg: shared FSM state type and parameter defaults for vin_wr_agen.
package vin_pkg;
    localparam int XY_W_DFLT      = 16;
    localparam int PIX_SHIFT_DFLT = 2;
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
endpackage

// File: rtl/vin_wr_agen_if.sv
// vin_wr_agen_if: pixel input stream and addressed write-request stream.
interface vin_wr_agen_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32
);
    logic [DATA_W-1:0] vin_dat;
    logic              vin_valid;
    logic              vin_ready;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_dat;
    modport slave  (input vin_dat, vin_valid, wr_ready, output vin_ready, wr_valid, wr_addr, wr_dat);
    modport master (output vin_dat, vin_valid, wr_ready, input vin_ready, wr_valid, wr_addr, wr_dat);
endinterface

// File: rtl/vin_wr_agen_xy_cnt.sv
// vin_xy_cnt: raster x/y counter with line wrap and last-pixel flag.
module vin_xy_cnt
    import vin_pkg::*;
#(
    parameter int XY_W = XY_W_DFLT
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            adv,
    input  logic [XY_W-1:0] xres,
    input  logic [XY_W-1:0] yres,
    output logic [XY_W-1:0] x,
    output logic [XY_W-1:0] y,
    output logic            last
);
    logic [XY_W-1:0] r_x, r_y;
    logic            w_xend;
    // compare x+1 against the resolution so a zero resolution never underflows
    assign w_xend = (r_x + XY_W'(1)) == xres;
    assign last   = w_xend && ((r_y + XY_W'(1)) == yres);
    assign x      = r_x;
    assign y      = r_y;
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (adv) begin
            r_x <= w_xend ? '0 : r_x + XY_W'(1);
            r_y <= w_xend ? r_y + XY_W'(1) : r_y;
        end
    end
endmodule

// File: rtl/vin_wr_agen.sv
// vin_wr_agen: turns a raster pixel stream into addressed write requests.
// Optional crop window is compiled in with VIN_CROP_EN.
module vin_wr_agen
    import vin_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int XY_W      = XY_W_DFLT,
    parameter int PIX_SHIFT = PIX_SHIFT_DFLT,
    parameter int ADDR_W    = 32
)(
    input  logic            vin_clk,
    input  logic            rst,
    input  logic            frame_sync_n,
    input  logic [XY_W-1:0] vin_xres,
    input  logic [XY_W-1:0] vin_yres,
`ifdef VIN_CROP_EN
    input  logic [XY_W-1:0] crop_x0,
    input  logic [XY_W-1:0] crop_y0,
    input  logic [XY_W-1:0] crop_w,
    input  logic [XY_W-1:0] crop_h,
`endif
    vin_wr_agen_if.slave    bus,
    output logic            frame_done,
    output logic            err_short,
    output logic            err_over
);
    localparam int FULL_W = 2 * XY_W + PIX_SHIFT;

    state_t              r_state, w_nxt;
    logic [XY_W-1:0]     r_xres, r_yres, w_x, w_y, w_dx, w_dy;
    logic                w_sync, w_acc, w_act, w_last, w_in, w_res_ok;
    logic                w_wr, w_done, w_over, w_short;
    logic                r_wr_valid, r_done, r_over, r_short;
    logic [ADDR_W-1:0]   r_wr_addr, w_addr;
    logic [DATA_W-1:0]   r_wr_dat;
    logic [FULL_W-1:0]   w_full;

    assign w_sync        = ~frame_sync_n;
    assign bus.vin_ready = ~rst & frame_sync_n & (~r_wr_valid | bus.wr_ready);
    assign w_acc         = bus.vin_valid & bus.vin_ready;
    assign w_act         = r_state == ACTIVE;
    assign w_res_ok      = (|vin_xres) && (|vin_yres);

    vin_xy_cnt #(.XY_W(XY_W)) u_cnt (
        .clk  (vin_clk),
        .rst  (rst),
        .clr  (w_sync),
        .adv  (w_acc & w_act),
        .xres (r_xres),
        .yres (r_yres),
        .x    (w_x),
        .y    (w_y),
        .last (w_last)
    );

`ifdef VIN_CROP_EN
    logic [XY_W-1:0] r_cx0, r_cy0, r_cw, r_ch;
    always_ff @(posedge vin_clk) begin
        if (rst) begin
            r_cx0 <= '0;
            r_cy0 <= '0;
            r_cw  <= '0;
            r_ch  <= '0;
        end else if (w_sync) begin
            r_cx0 <= crop_x0;
            r_cy0 <= crop_y0;
            r_cw  <= crop_w;
            r_ch  <= crop_h;
        end
    end
    // offsets are only trusted once the lower bound check has passed
    assign w_dx = w_x - r_cx0;
    assign w_dy = w_y - r_cy0;
    assign w_in = (w_x >= r_cx0) && (w_dx < r_cw) && (w_y >= r_cy0) && (w_dy < r_ch);
`else
    assign w_dx = w_x;
    assign w_dy = w_y;
    assign w_in = 1'b1;
`endif

    assign w_full = (FULL_W'(w_dy) << (XY_W + PIX_SHIFT)) | (FULL_W'(w_dx) << PIX_SHIFT);
    assign w_addr = ADDR_W'(w_full);

    always_comb begin
        w_nxt   = w_sync ? (w_res_ok ? ACTIVE : IDLE) : (w_acc && w_act && w_last) ? DRAIN : r_state;
        w_wr    = w_acc && w_act && w_in;
        w_done  = w_acc && w_act && w_last;
        w_over  = w_acc && !w_act;
        w_short = w_sync && w_act;
    end

    always_ff @(posedge vin_clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_xres  <= '0;
            r_yres  <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_sync) begin
                r_xres <= vin_xres;
                r_yres <= vin_yres;
            end
        end
    end

    always_ff @(posedge vin_clk) begin
        if (rst) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_dat   <= '0;
            r_done     <= 1'b0;
            r_over     <= 1'b0;
            r_short    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= w_addr;
                r_wr_dat   <= bus.vin_dat;
            end else if (bus.wr_ready) begin
                r_wr_valid <= 1'b0;
            end
            r_done  <= w_done;
            r_over  <= w_over;
            r_short <= w_short;
        end
    end

    assign bus.wr_valid = r_wr_valid;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_dat   = r_wr_dat;
    assign frame_done   = r_done;
    assign err_over     = r_over;
    assign err_short    = r_short;
endmodule

// File: tb/tb_vin_wr_agen.sv
// tb_vin_wr_agen: directed bench with a pixel-index reference model for vin_wr_agen.
module tb_vin_wr_agen;
    localparam int DW = 16, XW = 16, PS = 2, AW = 32;

    logic          clk = 1'b0, rst = 1'b1, fs_n = 1'b1;
    logic [XW-1:0] xres = '0, yres = '0;
    logic          fd, es, eo;
`ifdef VIN_CROP_EN
    logic [XW-1:0] cx0 = '0, cy0 = '0, cw = '0, ch = '0;
    int            mcx0, mcy0, mcw, mch;
`endif

    vin_wr_agen_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    vin_wr_agen #(.DATA_W(DW), .XY_W(XW), .PIX_SHIFT(PS), .ADDR_W(AW)) dut (
        .vin_clk      (clk),
        .rst          (rst),
        .frame_sync_n (fs_n),
        .vin_xres     (xres),
        .vin_yres     (yres),
`ifdef VIN_CROP_EN
        .crop_x0      (cx0),
        .crop_y0      (cy0),
        .crop_w       (cw),
        .crop_h       (ch),
`endif
        .bus          (bus),
        .frame_done   (fd),
        .err_short    (es),
        .err_over     (eo)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit en = 0;
    logic [31:0] q_addr[$];
    logic [15:0] q_dat[$];
    int done_cnt = 0, over_cnt = 0, short_cnt = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic logic [31:0] pix_addr(input int x, input int y);
        logic [63:0] a;
        a = (64'(y) << (XW + PS)) | (64'(x) << PS);
        return a[31:0];
    endfunction

    // reference model: frame progress tracked as a linear pixel index
    logic        m_wv = 0, m_done = 0, m_over = 0, m_short = 0, m_open = 0;
    logic [31:0] m_wa = '0, m_a;
    logic [15:0] m_wd = '0;
    int          m_idx = 0, m_xres = 0, m_yres = 0, px, py;
    logic        m_rdy, m_acc, m_wr;

    always @(posedge clk) begin
        if (rst) begin
            m_wv = 0; m_wa = '0; m_wd = '0;
            m_done = 0; m_over = 0; m_short = 0; m_open = 0; m_idx = 0;
        end else begin
            m_rdy = fs_n && (!m_wv || bus.wr_ready);
            m_acc = bus.vin_valid && m_rdy;
            m_wr = 0; m_a = '0;
            m_done = 0; m_over = 0; m_short = 0;
            if (!fs_n) begin
                m_short = m_open;
                m_xres = int'(xres); m_yres = int'(yres);
                m_idx = 0;
                m_open = (xres != 0) && (yres != 0);
`ifdef VIN_CROP_EN
                mcx0 = int'(cx0); mcy0 = int'(cy0); mcw = int'(cw); mch = int'(ch);
`endif
            end else if (m_acc) begin
                if (m_open) begin
                    px = m_idx % m_xres;
                    py = m_idx / m_xres;
`ifdef VIN_CROP_EN
                    if (px >= mcx0 && px < mcx0 + mcw && py >= mcy0 && py < mcy0 + mch) begin
                        m_wr = 1;
                        m_a = pix_addr(px - mcx0, py - mcy0);
                    end
`else
                    m_wr = 1;
                    m_a = pix_addr(px, py);
`endif
                    m_idx++;
                    if (m_idx == m_xres * m_yres) begin
                        m_open = 0;
                        m_done = 1;
                    end
                end else m_over = 1;
            end
            if (m_wr) begin
                m_wv = 1; m_wa = m_a; m_wd = bus.vin_dat;
            end else if (bus.wr_ready) m_wv = 0;
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("vin_ready", bus.vin_ready, !rst && fs_n && (!m_wv || bus.wr_ready));
            chk("wr_valid", bus.wr_valid, m_wv);
            chk("wr_addr", bus.wr_addr, m_wa);
            chk("wr_dat", bus.wr_dat, m_wd);
            chk("frame_done", fd, m_done);
            chk("err_over", eo, m_over);
            chk("err_short", es, m_short);
            if (bus.wr_valid && bus.wr_ready) begin
                q_addr.push_back(bus.wr_addr);
                q_dat.push_back(bus.wr_dat);
            end
            if (fd) done_cnt++;
            if (eo) over_cnt++;
            if (es) short_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.vin_valid = 0;
        repeat (n) tick();
    endtask

    task automatic clear();
        q_addr.delete(); q_dat.delete();
        done_cnt = 0; over_cnt = 0; short_cnt = 0;
    endtask

    task automatic sync(input int xr, input int yr);
        xres = XW'(xr); yres = XW'(yr);
        bus.vin_valid = 0;
        fs_n = 0;
        tick();
        fs_n = 1;
    endtask

    task automatic beat(input logic [15:0] d);
        logic got, r;
        got = 0;
        bus.vin_valid = 1;
        bus.vin_dat = d;
        for (int k = 0; k < 50 && !got; k++) begin
            #1 r = bus.vin_ready;
            tick();
            got = r;
        end
        chk("beat_accept", got, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [31:0] exp26[8];
        exp26 = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40000, 32'h40004, 32'h40008, 32'h4000C};
        bus.vin_valid = 0; bus.vin_dat = '0; bus.wr_ready = 1;
        tick();
        en = 1;
        repeat (2) tick();
        chk("rst_wr_valid", bus.wr_valid, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_vin_ready", bus.vin_ready, 0);
        rst = 0;
        tick();

`ifndef VIN_CROP_EN
        // 4x2 frame, continuous flow
        clear();
        sync(4, 2);
        for (int i = 0; i < 8; i++) beat(16'h100 + 16'(i));
        idle(3);
        chk("t1_count", q_addr.size(), 8);
        for (int i = 0; i < 8 && i < q_addr.size(); i++) begin
            chk("t1_addr", q_addr[i], exp26[i]);
            chk("t1_dat", q_dat[i], 16'h100 + 16'(i));
        end
        chk("t1_done_cnt", done_cnt, 1);

        // write-side stall at pixel 2
        clear();
        sync(4, 2);
        for (int i = 0; i < 3; i++) beat(16'h200 + 16'(i));
        bus.wr_ready = 0;
        bus.vin_valid = 1;
        bus.vin_dat = 16'h203;
        repeat (3) begin
            #1 chk("t2_stall_ready", bus.vin_ready, 0);
            chk("t2_stall_addr", bus.wr_addr, 32'h8);
            tick();
        end
        bus.wr_ready = 1;
        for (int i = 3; i < 8; i++) beat(16'h200 + 16'(i));
        idle(3);
        chk("t2_count", q_addr.size(), 8);
        for (int i = 0; i < 8 && i < q_dat.size(); i++) chk("t2_dat", q_dat[i], 16'h200 + 16'(i));

        // overrun after last pixel
        clear();
        beat(16'h300); beat(16'h301);
        idle(2);
        chk("t3_over_cnt", over_cnt, 2);
        chk("t3_count", q_addr.size(), 0);

        // short frame restart with a pending word
        clear();
        sync(4, 2);
        for (int i = 0; i < 5; i++) beat(16'h400 + 16'(i));
        bus.wr_ready = 0;
        sync(4, 2);
        bus.wr_ready = 1;
        beat(16'h410);
        idle(3);
        chk("t4_short_cnt", short_cnt, 1);
        chk("t4_count", q_addr.size(), 6);
        if (q_addr.size() == 6) begin
            chk("t4_pending_addr", q_addr[4], 32'h40000);
            chk("t4_restart_addr", q_addr[5], 32'h0);
            chk("t4_restart_dat", q_dat[5], 16'h410);
        end

        // zero resolution stays idle
        clear();
        sync(0, 2);
        for (int i = 0; i < 3; i++) beat(16'h500 + 16'(i));
        idle(2);
        chk("t5_over_cnt", over_cnt, 3);
        chk("t5_count", q_addr.size(), 0);

        // reset mid-frame discards pending word
        sync(4, 2);
        beat(16'h600); beat(16'h601);
        bus.wr_ready = 0;
        bus.vin_valid = 0;
        rst = 1;
        repeat (2) tick();
        rst = 0;
        bus.wr_ready = 1;
        clear();
        chk("t6_wr_valid", bus.wr_valid, 0);
        beat(16'h602); beat(16'h603);
        idle(2);
        chk("t6_count", q_addr.size(), 0);
        chk("t6_over_cnt", over_cnt, 2);
        sync(4, 2);
        beat(16'h610);
        idle(2);
        chk("t6_resume_count", q_addr.size(), 1);
        if (q_addr.size() == 1) chk("t6_resume_addr", q_addr[0], 32'h0);
`else
        // 8x4 frame cropped to a 2x2 window at (2,1)
        clear();
        cx0 = 2; cy0 = 1; cw = 2; ch = 2;
        sync(8, 4);
        for (int i = 0; i < 32; i++) beat(16'h700 + 16'(i));
        idle(3);
        chk("crop_count", q_addr.size(), 4);
        if (q_addr.size() == 4) begin
            chk("crop_addr0", q_addr[0], 32'h0);
            chk("crop_addr1", q_addr[1], 32'h4);
            chk("crop_addr2", q_addr[2], 32'h40000);
            chk("crop_addr3", q_addr[3], 32'h40004);
            chk("crop_dat0", q_dat[0], 16'h70A);
        end
        chk("crop_done_cnt", done_cnt, 1);
`endif
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vin_wr_agen.md
VIN_WR_AGEN -- requirements
Module: vin_wr_agen

Interface
REQ-001 Parameters SHALL be: DATA_W, 16, pixel data width; XY_W, 16, width of the x/y counters and resolution inputs; PIX_SHIFT, 2, byte-address shift per pixel; ADDR_W, 32, output address width.
REQ-002 Port vin_clk, in, 1: the single clock; all logic SHALL be rising-edge.
REQ-003 Port rst, in, 1: synchronous reset, active-high.
REQ-004 Port frame_sync_n, in, 1: active-low frame start; the cycle it is low SHALL act as a frame restart.
REQ-005 Ports vin_dat (in, DATA_W), vin_valid (in, 1), vin_ready (out, 1): input pixel stream, valid/ready.
REQ-006 Ports vin_xres and vin_yres, in, XY_W: frame width and height in pixels; sampled at frame start.
REQ-007 Ports wr_valid (out, 1), wr_ready (in, 1), wr_addr (out, ADDR_W), wr_dat (out, DATA_W): registered write request stream.
REQ-008 Ports frame_done (out, 1), err_short (out, 1), err_over (out, 1): single-cycle status pulses.
REQ-009 With VIN_CROP_EN defined, ports crop_x0, crop_y0, crop_w and crop_h SHALL exist, each in, XY_W.

Function
REQ-010 FSM states SHALL be IDLE, ACTIVE and DRAIN.
- IDLE -> ACTIVE on frame_sync_n low.
- ACTIVE -> DRAIN when the last pixel (x=xres-1, y=yres-1) is accepted.
- DRAIN -> IDLE on frame_sync_n low, or re-enter ACTIVE directly on frame_sync_n low.
REQ-011 On frame_sync_n low, the block SHALL latch xres/yres (and crop values), clear x/y, and enter ACTIVE.
REQ-012 An input beat SHALL be accepted when vin_valid && vin_ready.
REQ-013 vin_ready SHALL equal ~wr_valid | wr_ready in every state except when rst is high or frame_sync_n is low, where it SHALL be 0.
REQ-014 In ACTIVE, each accepted beat SHALL advance x.
- x wraps to 0 at xres-1 and increments y.
- There is no dead first beat: the first accepted beat is pixel (0,0).
REQ-015 An accepted beat SHALL load the output register one cycle later.
- wr_valid=1, wr_dat=vin_dat, wr_addr=(y << (XY_W+PIX_SHIFT)) | (x << PIX_SHIFT), zero-extended or truncated to ADDR_W.
- The output register holds until wr_valid && wr_ready.
REQ-016 Beats accepted in IDLE or DRAIN SHALL be consumed, produce no write, and pulse err_over once per beat.
REQ-017 frame_done SHALL pulse one cycle after the last pixel is accepted.
REQ-018 frame_sync_n low while in ACTIVE SHALL pulse err_short and restart the frame; a pending output word SHALL still complete.
REQ-019 xres=0 or yres=0 SHALL keep the FSM in IDLE, with no writes and every beat treated as overrun.
REQ-020 Counter arithmetic SHALL be XY_W-bit unsigned, and comparisons SHALL be done without underflow (x+1==xres, not x<xres-1).

Reset
REQ-021 When rst is high, the block SHALL enter IDLE with x=y=0, wr_valid=0, wr_addr=0, wr_dat=0, and frame_done=err_short=err_over=0, overriding all other inputs.
REQ-022 Reset mid-frame SHALL discard any pending output word; the next write only follows a new frame_sync_n.

Configuration
REQ-023 Macro VIN_CROP_EN:
- Defined: only pixels with crop_x0<=x<crop_x0+crop_w and crop_y0<=y<crop_y0+crop_h are written, at address ((y-crop_y0),(x-crop_x0)) packed as in REQ-015; other accepted pixels are consumed silently.
- Undefined: full frame is written and the crop ports are absent.

Structure
REQ-024 Package vin_pkg SHALL hold the FSM state enum and the default values of PIX_SHIFT and XY_W.
REQ-025 Sub-module vin_xy_cnt SHALL implement the x/y raster counter with wrap and last-pixel flag.

Verification
REQ-026 xres=4, yres=2, continuous valid, wr_ready=1: 8 writes at addr 0x0,0x4,0x8,0xC,0x40000,...,0x4000C; frame_done one cycle after the 8th accept.
REQ-027 Same frame with wr_ready low for 3 cycles at pixel 2: vin_ready=0 during the stall, wr_addr=0x8 held, no data loss, final count 8.
REQ-028 2 extra beats after the last pixel: 2 err_over pulses and no writes.
REQ-029 frame_sync_n low after 5 pixels: err_short pulse, next accept written at addr 0x0.
REQ-030 rst asserted mid-frame then released without frame_sync_n: wr_valid=0 and no writes until frame_sync_n.
REQ-031 VIN_CROP_EN, 8x4 frame, crop (2,1,2,2): exactly 4 writes at addr 0x0,0x4,0x40000,0x40004.
